mips8_run_ctrl: RTL and testbench
=================================

# mips8_run_ctrl

Wishbone-mapped run controller for the 8-bit MIPS core in the user project area. Holds the core in reset, lets firmware load instruction memory while the core is stopped, then runs, single-steps or halts it. Sits between the user_project_wrapper Wishbone slave port and the core's reset, clock-enable and instruction-memory write port. Raises a sticky interrupt when the core stops itself.

## Interface
- BASE_ADDR, 32'h3000_0000, Wishbone base; block decodes BASE_ADDR[31:4]
- IMEM_AW, 8, instruction-memory address width (max 8)

- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  asynchronous, active-high reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write
- wbs_sel_i  in  4  byte lanes
- wbs_adr_i  in  32  address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- core_rst_o  out  1  core reset, active high
- core_en_o  out  1  core clock enable
- core_halt_i  in  1  core reached its halt instruction (level)
- imem_we_o  out  1  instruction-memory write strobe
- imem_addr_o  out  IMEM_AW  write address
- imem_wdata_o  out  8  write data
- irq_o  out  1  sticky halt interrupt (routes to user_irq[0])

## Operation
- Register map (offset = wbs_adr_i[3:2]):
  - 0x0 CTRL: W bit0 RUN, bit1 STEP, bit2 HALT, bit3 CORE_RESET (lane 0 only); R {30'b0, state[1:0]}
  - 0x4 IMEM: W {16'x, addr[15:8], data[7:0]}; needs wbs_sel_i[1:0]==2'b11 else ignored; R 0
  - 0x8 STATUS: R {28'b0, imem_err, irq, state[1:0]}; W1C bit2 clears irq, bit3 clears imem_err
  - 0xC CYCLES: see Configuration; reads 0 when compiled out
- States: RESET_HOLD=0, HALTED=1, RUN=2, STEP=3.
  - RESET_HOLD: core_rst_o=1, core_en_o=0. Goes to HALTED on a CTRL write with bit3=0.
  - HALTED: core_rst_o=0, core_en_o=0. RUN bit goes to RUN; STEP bit goes to STEP.
  - RUN: core_en_o=1. HALT bit goes to HALTED. core_halt_i=1 goes to HALTED and sets irq.
  - STEP: core_en_o=1 for exactly one cycle, then HALTED. Sets irq if core_halt_i is sampled high.
  - CTRL bit3=1 from any state goes to RESET_HOLD.
- CTRL priority when several bits are set: CORE_RESET > HALT > RUN > STEP.
- RUN or STEP written while already in RUN: no effect.
- IMEM write accepted only in RESET_HOLD or HALTED:
  - imem_we_o pulses for one cycle; imem_addr_o = data[8+IMEM_AW-1:8], imem_wdata_o = data[7:0].
  - Otherwise no strobe, and imem_err is set (sticky). The bus transfer is still acked.
- Address decode: transfer claimed only if wbs_adr_i[31:4]==BASE_ADDR[31:4]; otherwise no ack and no side effect.
- irq_o = irq bit. It stays set until a W1C write or reset.

## Timing
- Reset values:
  - State RESET_HOLD; core_rst_o=1.
  - core_en_o, imem_we_o, wbs_ack_o, irq_o = 0.
  - wbs_dat_o, imem_addr_o, imem_wdata_o, imem_err, CYCLES = 0.
- Ack: registered. It rises on the edge after stb&cyc&decode is seen with ack low, and lasts one cycle. Minimum two cycles per transfer; never back-to-back.
- Write side effects (state change, imem_we_o, W1C) take effect on the same edge that raises ack.
- wbs_dat_o is valid only while ack=1 and is 0 otherwise. Read data is the value before that cycle's write.
- Simultaneous events:
  - core_halt_i in the same cycle as a RUN or HALT write: final state HALTED, irq set.
  - core_halt_i in the same cycle as a W1C irq clear: irq stays set (set wins).
- Reset asserted mid-transfer or mid-step: immediate return to reset values; the pending ack is dropped.

## Configuration
- MIPS8_CYCLE_COUNTER_EN defined:
  - 32-bit CYCLES counter increments every cycle core_en_o=1 and wraps at 0xFFFF_FFFF to 0.
  - Cleared to 0 by reset and on every entry to RESET_HOLD.
  - Read at 0xC; writes ignored.
- MIPS8_CYCLE_COUNTER_EN undefined: no counter logic; 0xC reads 0.

## Test plan
- Reset, then read CTRL -> 0x0, core_rst_o=1, core_en_o=0, all other outputs 0.
- Write CTRL=0x0, then IMEM=0x0000_1234 -> state HALTED; imem_we_o one cycle with addr=0x12, data=0x34; imem_err=0.
- Write CTRL=0x1 (RUN), then IMEM=0x0000_0555 -> no imem_we_o; STATUS reads 0xA (imem_err=1, RUN); write STATUS=0x8 -> err cleared.
- From HALTED write CTRL=0x2 -> core_en_o high exactly 1 cycle; state back to 1; CYCLES=1 with the macro.
- In RUN raise core_halt_i -> next edge state HALTED, irq_o=1; write STATUS=0x4 -> irq_o=0; write CTRL=0x9 -> RESET_HOLD, core_rst_o=1.
- Address 0x3000_0010 with stb/cyc for 5 cycles -> wbs_ack_o stays 0, no state change.

Source files
------------

// File: rtl/mips8_run_ctrl.sv
// Wishbone run controller for the 8-bit MIPS core: reset hold, IMEM load, run/step/halt, sticky halt irq.
// Optional CYCLES counter at offset 0xC is compiled in with `define MIPS8_CYCLE_COUNTER_EN.
module mips8_run_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned IMEM_AW   = 8
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               wbs_stb_i,
   input  logic               wbs_cyc_i,
   input  logic               wbs_we_i,
   input  logic [3:0]         wbs_sel_i,
   input  logic [31:0]        wbs_adr_i,
   input  logic [31:0]        wbs_dat_i,
   output logic               wbs_ack_o,
   output logic [31:0]        wbs_dat_o,
   output logic               core_rst_o,
   output logic               core_en_o,
   input  logic               core_halt_i,
   output logic               imem_we_o,
   output logic [IMEM_AW-1:0] imem_addr_o,
   output logic [7:0]         imem_wdata_o,
   output logic               irq_o
);

   typedef enum logic [1:0] {
      ST_RESET_HOLD = 2'd0,
      ST_HALTED     = 2'd1,
      ST_RUN        = 2'd2,
      ST_STEP       = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic               ack_q, ack_d;
   logic [31:0]        dat_q, dat_d;
   logic               core_rst_q, core_rst_d;
   logic               core_en_q, core_en_d;
   logic               imem_we_q, imem_we_d;
   logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
   logic [7:0]         imem_wdata_q, imem_wdata_d;
   logic               irq_q, irq_d;
   logic               imem_err_q, imem_err_d;
`ifdef MIPS8_CYCLE_COUNTER_EN
   logic [31:0]        cycles_q, cycles_d;
`endif

   logic        hit, access, wr;
   logic [1:0]  offset;
   logic        ctrl_wr, imem_wr, stat_wr, imem_ok, irq_set;
   logic [1:0]  state_bits;
   logic [31:0] rdata;
   logic        unused_bits;

   assign hit     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign access  = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
   assign wr      = access & wbs_we_i;
   assign offset  = wbs_adr_i[3:2];
   assign ctrl_wr = wr & (offset == 2'd0) & wbs_sel_i[0];
   assign imem_wr = wr & (offset == 2'd1) & (wbs_sel_i[1:0] == 2'b11);
   assign stat_wr = wr & (offset == 2'd2) & wbs_sel_i[0];
   assign imem_ok = (state_q == ST_RESET_HOLD) || (state_q == ST_HALTED);
   assign state_bits = state_q;
   assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

   // Halt from the core outranks any concurrent RUN/HALT request; CORE_RESET outranks everything.
   always_comb begin
      state_d = state_q;
      irq_set = 1'b0;
      case (state_q)
         ST_RESET_HOLD: begin
            if (ctrl_wr && !wbs_dat_i[3]) state_d = ST_HALTED;
         end
         ST_HALTED: begin
            if (ctrl_wr && !wbs_dat_i[2]) begin
               if (wbs_dat_i[0]) begin
                  if (core_halt_i) irq_set = 1'b1;
                  else             state_d = ST_RUN;
               end else if (wbs_dat_i[1]) begin
                  state_d = ST_STEP;
               end
            end
         end
         ST_RUN: begin
            if (core_halt_i) begin
               state_d = ST_HALTED;
               irq_set = 1'b1;
            end else if (ctrl_wr && wbs_dat_i[2]) begin
               state_d = ST_HALTED;
            end
         end
         ST_STEP: begin
            state_d = ST_HALTED;
            if (core_halt_i) irq_set = 1'b1;
         end
         default: state_d = ST_RESET_HOLD;
      endcase
      if (ctrl_wr && wbs_dat_i[3]) state_d = ST_RESET_HOLD;
   end

   always_comb begin
      rdata = '0;
      case (offset)
         2'd0: rdata = {30'b0, state_bits};
         2'd1: rdata = '0;
         2'd2: rdata = {28'b0, imem_err_q, irq_q, state_bits};
`ifdef MIPS8_CYCLE_COUNTER_EN
         2'd3: rdata = cycles_q;
`else
         2'd3: rdata = '0;
`endif
         default: rdata = '0;
      endcase
   end

   always_comb begin
      ack_d        = access;
      dat_d        = (access && !wbs_we_i) ? rdata : '0;
      core_rst_d   = (state_d == ST_RESET_HOLD);
      core_en_d    = (state_d == ST_RUN) || (state_d == ST_STEP);
      imem_we_d    = imem_wr & imem_ok;
      imem_addr_d  = imem_we_d ? wbs_dat_i[8 +: IMEM_AW] : imem_addr_q;
      imem_wdata_d = imem_we_d ? wbs_dat_i[7:0] : imem_wdata_q;
      irq_d        = irq_set | (irq_q & ~(stat_wr & wbs_dat_i[2]));
      imem_err_d   = (imem_wr & ~imem_ok) | (imem_err_q & ~(stat_wr & wbs_dat_i[3]));
`ifdef MIPS8_CYCLE_COUNTER_EN
      if (state_d == ST_RESET_HOLD) cycles_d = '0;
      else if (core_en_q)           cycles_d = cycles_q + 32'd1;
      else                          cycles_d = cycles_q;
`endif
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q      <= ST_RESET_HOLD;
         ack_q        <= 1'b0;
         dat_q        <= '0;
         core_rst_q   <= 1'b1;
         core_en_q    <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         irq_q        <= 1'b0;
         imem_err_q   <= 1'b0;
`ifdef MIPS8_CYCLE_COUNTER_EN
         cycles_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         ack_q        <= ack_d;
         dat_q        <= dat_d;
         core_rst_q   <= core_rst_d;
         core_en_q    <= core_en_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         irq_q        <= irq_d;
         imem_err_q   <= imem_err_d;
`ifdef MIPS8_CYCLE_COUNTER_EN
         cycles_q     <= cycles_d;
`endif
      end
   end

   assign wbs_ack_o    = ack_q;
   assign wbs_dat_o    = dat_q;
   assign core_rst_o   = core_rst_q;
   assign core_en_o    = core_en_q;
   assign imem_we_o    = imem_we_q;
   assign imem_addr_o  = imem_addr_q;
   assign imem_wdata_o = imem_wdata_q;
   assign irq_o        = irq_q;

endmodule

// File: tb/tb_mips8_run_ctrl.sv
// Directed self-checking bench for mips8_run_ctrl; honours `define MIPS8_CYCLE_COUNTER_EN for CYCLES expectations.
module tb_mips8_run_ctrl;

   localparam logic [31:0] A_CTRL = 32'h3000_0000;
   localparam logic [31:0] A_IMEM = 32'h3000_0004;
   localparam logic [31:0] A_STAT = 32'h3000_0008;
   localparam logic [31:0] A_CYC  = 32'h3000_000C;
`ifdef MIPS8_CYCLE_COUNTER_EN
   localparam logic [31:0] STEP_CYC = 32'd1;
`else
   localparam logic [31:0] STEP_CYC = 32'd0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        stb, cyc, we;
   logic [3:0]  sel;
   logic [31:0] adr, wdat;
   logic        ack;
   logic [31:0] rdat;
   logic        core_rst, core_en, core_halt, imem_we, irq;
   logic [7:0]  imem_addr, imem_wdata;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   logic [31:0] rd_val;
   logic        ack_we, ack_en, ack_rst, ack_irq, after_we, after_en, after_irq;
   logic [7:0]  ack_addr, ack_wdata;

   mips8_run_ctrl #(.BASE_ADDR(32'h3000_0000), .IMEM_AW(8)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .wbs_stb_i   (stb),
      .wbs_cyc_i   (cyc),
      .wbs_we_i    (we),
      .wbs_sel_i   (sel),
      .wbs_adr_i   (adr),
      .wbs_dat_i   (wdat),
      .wbs_ack_o   (ack),
      .wbs_dat_o   (rdat),
      .core_rst_o  (core_rst),
      .core_en_o   (core_en),
      .core_halt_i (core_halt),
      .imem_we_o   (imem_we),
      .imem_addr_o (imem_addr),
      .imem_wdata_o(imem_wdata),
      .irq_o       (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input logic halt);
      logic got;
      got       = 1'b0;
      adr       = a;
      we        = w;
      wdat      = d;
      sel       = s;
      core_halt = halt;
      stb       = 1'b1;
      cyc       = 1'b1;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (ack) got = 1'b1;
      end
      check("ack_seen", {31'b0, got}, 32'd1);
      rd_val    = rdat;
      ack_we    = imem_we;
      ack_addr  = imem_addr;
      ack_wdata = imem_wdata;
      ack_en    = core_en;
      ack_rst   = core_rst;
      ack_irq   = irq;
      stb       = 1'b0;
      cyc       = 1'b0;
      we        = 1'b0;
      core_halt = 1'b0;
      @(posedge clk); #1;
      after_we  = imem_we;
      after_en  = core_en;
      after_irq = irq;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      xfer(a, 1'b1, d, 4'hF, 1'b0);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      xfer(a, 1'b0, 32'h0, 4'hF, 1'b0);
      check(tag, rd_val, exp);
   endtask

   initial begin
      int unsigned acks, strobes;
      rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
      adr = '0; wdat = '0; core_halt = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_core_rst", {31'b0, core_rst}, 32'd1);
      check("rst_core_en",  {31'b0, core_en}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_ack",   {31'b0, ack}, 32'd0);
      check("rst_dat",   rdat, 32'd0);
      check("rst_we",    {31'b0, imem_we}, 32'd0);
      check("rst_irq",   {31'b0, irq}, 32'd0);
      check("rst_addr",  {24'b0, imem_addr}, 32'd0);
      check("rst_wdata", {24'b0, imem_wdata}, 32'd0);
      check("rst_core_rst2", {31'b0, core_rst}, 32'd1);

      rd_chk("ctrl_reset", A_CTRL, 32'h0);
      rd_chk("stat_reset", A_STAT, 32'h0);
      rd_chk("imem_read0", A_IMEM, 32'h0);
      check("dat_idle_zero", rdat, 32'h0);
      rd_chk("cyc_reset", A_CYC, 32'h0);

      wr(A_CTRL, 32'h0);
      check("halted_core_rst", {31'b0, ack_rst}, 32'd0);
      rd_chk("ctrl_halted", A_CTRL, 32'h1);

      wr(A_IMEM, 32'h0000_1234);
      check("imem_we_pulse", {31'b0, ack_we}, 32'd1);
      check("imem_addr",     {24'b0, ack_addr}, 32'h12);
      check("imem_wdata",    {24'b0, ack_wdata}, 32'h34);
      check("imem_we_once",  {31'b0, after_we}, 32'd0);
      rd_chk("stat_no_err", A_STAT, 32'h1);

      xfer(A_IMEM, 1'b1, 32'h0000_5678, 4'b0001, 1'b0);
      check("imem_sel_ignored", {31'b0, ack_we}, 32'd0);
      rd_chk("stat_sel_no_err", A_STAT, 32'h1);

      wr(A_CTRL, 32'h2);
      check("step_en_on",  {31'b0, ack_en}, 32'd1);
      check("step_en_off", {31'b0, after_en}, 32'd0);
      rd_chk("ctrl_after_step", A_CTRL, 32'h1);
      rd_chk("cyc_after_step", A_CYC, STEP_CYC);

      wr(A_CTRL, 32'h1);
      check("run_en", {31'b0, ack_en}, 32'd1);
      rd_chk("ctrl_run", A_CTRL, 32'h2);
      wr(A_IMEM, 32'h0000_0555);
      check("imem_blocked_run", {31'b0, ack_we}, 32'd0);
      rd_chk("stat_err_run", A_STAT, 32'hA);
      wr(A_STAT, 32'h8);
      rd_chk("stat_err_clr", A_STAT, 32'h2);

      wr(A_CTRL, 32'h2);
      rd_chk("run_ignores_step", A_CTRL, 32'h2);
      wr(A_CTRL, 32'h1);
      rd_chk("run_ignores_run", A_CTRL, 32'h2);

      core_halt = 1'b1;
      @(posedge clk); #1;
      core_halt = 1'b0;
      check("halt_en_off", {31'b0, core_en}, 32'd0);
      check("halt_irq",    {31'b0, irq}, 32'd1);
      rd_chk("ctrl_core_halted", A_CTRL, 32'h1);
      rd_chk("stat_irq", A_STAT, 32'h5);
      wr(A_STAT, 32'h4);
      check("irq_w1c", {31'b0, ack_irq}, 32'd0);

      wr(A_CTRL, 32'h7);
      rd_chk("prio_halt_over_run", A_CTRL, 32'h1);
      wr(A_CTRL, 32'h3);
      rd_chk("prio_run_over_step", A_CTRL, 32'h2);
      wr(A_CTRL, 32'h6);
      rd_chk("prio_halt_in_run", A_CTRL, 32'h1);

      xfer(A_CTRL, 1'b1, 32'h1, 4'hF, 1'b1);
      check("run_wr_halt_irq", {31'b0, ack_irq}, 32'd1);
      rd_chk("run_wr_halt_state", A_CTRL, 32'h1);
      wr(A_STAT, 32'h4);

      wr(A_CTRL, 32'h1);
      xfer(A_CTRL, 1'b1, 32'h4, 4'hF, 1'b1);
      check("halt_wr_halt_irq", {31'b0, ack_irq}, 32'd1);
      rd_chk("halt_wr_halt_state", A_CTRL, 32'h1);
      wr(A_CTRL, 32'h1);
      xfer(A_STAT, 1'b1, 32'h4, 4'hF, 1'b1);
      check("w1c_set_wins", {31'b0, after_irq}, 32'd1);
      rd_chk("stat_set_wins", A_STAT, 32'h5);
      wr(A_STAT, 32'h4);
      check("irq_cleared2", {31'b0, after_irq}, 32'd0);

      wr(A_CTRL, 32'h9);
      check("reset_hold_rst", {31'b0, ack_rst}, 32'd1);
      check("reset_hold_en",  {31'b0, ack_en}, 32'd0);
      rd_chk("ctrl_reset_hold", A_CTRL, 32'h0);
      rd_chk("cyc_cleared", A_CYC, 32'h0);

      wr(A_IMEM, 32'h00AB_7F01);
      check("imem_we_hold",    {31'b0, ack_we}, 32'd1);
      check("imem_addr_hold",  {24'b0, ack_addr}, 32'h7F);
      check("imem_wdata_hold", {24'b0, ack_wdata}, 32'h01);

      acks = 0;
      strobes = 0;
      adr = 32'h3000_0010; we = 1'b1; wdat = 32'h0; sel = 4'hF;
      stb = 1'b1; cyc = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (ack)     acks++;
         if (imem_we) strobes++;
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      check("miss_no_ack", acks, 32'd0);
      check("miss_no_strobe", strobes, 32'd0);
      rd_chk("miss_no_state", A_CTRL, 32'h0);

      wr(A_CTRL, 32'h0);
      wr(A_CTRL, 32'h1);
      adr = A_CTRL; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
      @(posedge clk); #1;
      check("mid_ack_up",  {31'b0, ack}, 32'd1);
      check("mid_dat_run", rdat, 32'h2);
      #2 rst = 1'b1;
      #1;
      check("mid_ack_drop", {31'b0, ack}, 32'd0);
      check("mid_dat_zero", rdat, 32'h0);
      check("mid_core_rst", {31'b0, core_rst}, 32'd1);
      check("mid_core_en",  {31'b0, core_en}, 32'd0);
      stb = 1'b0; cyc = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rd_chk("post_reset_ctrl", A_CTRL, 32'h0);
      rd_chk("post_reset_cyc", A_CYC, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
